// File: rtl/strait_test_pkg.sv
// Shared types and sizing helpers for the array self-test sequencer.
// Pattern-set selectors, default depths and the FSM state encoding.
package strait_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE,
    ST_FIN
  } seq_state_e;

  localparam logic TEST_SA = 1'b0;
  localparam logic TEST_TD = 1'b1;

  localparam int SA_DEPTH_DEF = 12;
  localparam int TD_DEPTH_DEF = 18;

  // Index width able to address the deeper of two pattern sets.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/fault_line_counter.sv
// Counts set bits in one row/column slice of the fault map and flags
// the line when the count reaches the threshold.
module fault_line_counter #(
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 4,
  parameter int THRESHOLD = 2
) (
  input  logic [WIDTH-1:0] bits,
  output logic             flagged
);

  logic [CNT_W-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + CNT_W'(bits[i]);
  end

  assign flagged = (cnt >= CNT_W'(THRESHOLD));

endmodule

// File: rtl/envm_test_sequencer.sv
// BIST sequencer: walks SA/TD pattern sets through the array test engine,
// OR-accumulates per-PE faults, then writes the fault map back row by row.
module envm_test_sequencer
  import strait_test_pkg::*;
#(
  parameter int SYSTOLIC_SIZE         = 8,
  parameter int ADDR_WIDTH            = $clog2(SYSTOLIC_SIZE),
  parameter int SA_TEST_PATTERN_DEPTH = SA_DEPTH_DEF,
  parameter int TD_TEST_PATTERN_DEPTH = TD_DEPTH_DEF,
  parameter int MAX_ADDR_WIDTH        = cnt_width(SA_TEST_PATTERN_DEPTH, TD_TEST_PATTERN_DEPTH),
  parameter int LINE_FAULT_THRESHOLD  = 2,
  parameter int TIMEOUT_CYCLES        = 255
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   sa_en,
  input  logic                                   td_en,
  output logic                                   test_type,
  output logic [MAX_ADDR_WIDTH-1:0]              test_counter,
  output logic                                   pat_valid,
  input  logic                                   pat_ready,
  input  logic                                   res_valid,
  input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0] res_fault_flat,
  output logic                                   detection_en,
  output logic [ADDR_WIDTH-1:0]                  counter,
  output logic [SYSTOLIC_SIZE-1:0]               single_pe_detection,
  output logic                                   row_fault_detection,
  output logic                                   column_fault_detection,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   timeout_err,
  output logic                                   fault_found
);

  localparam int S  = SYSTOLIC_SIZE;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = ADDR_WIDTH + 1;

  seq_state_e state, state_nxt;

  logic                      td_q;
  logic                      type_q;
  logic [MAX_ADDR_WIDTH-1:0] idx_q;
  logic [TW-1:0]             tcnt_q;
  logic [ADDR_WIDTH-1:0]     row_q;
  logic [S*S-1:0]            acc_q;
  logic                      done_q, timeout_q, fault_q;

  logic last_pat, to_td, tmo_hit, last_row;
  logic [S-1:0] row_vec, col_vec;
  logic row_flag, col_flag;

  assign last_pat = (type_q == TEST_TD)
                  ? (idx_q == MAX_ADDR_WIDTH'(TD_TEST_PATTERN_DEPTH - 1))
                  : (idx_q == MAX_ADDR_WIDTH'(SA_TEST_PATTERN_DEPTH - 1));
  assign to_td    = (type_q == TEST_SA) && td_q;
  assign tmo_hit  = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign last_row = (row_q == ADDR_WIDTH'(S - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (sa_en || td_en) ? ST_ISSUE : ST_FIN;
      ST_ISSUE: if (pat_ready) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (res_valid)    state_nxt = (last_pat && !to_td) ? ST_STORE : ST_ISSUE;
        else if (tmo_hit) state_nxt = ST_STORE;
      end
      ST_STORE: if (last_row) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      td_q      <= 1'b0;
      type_q    <= TEST_SA;
      idx_q     <= '0;
      tcnt_q    <= '0;
      row_q     <= '0;
      acc_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      // done trails FIN by a cycle so it lands in IDLE and never overlaps busy
      done_q <= (state == ST_FIN);
      case (state)
        ST_IDLE: if (start) begin
          td_q      <= td_en;
          type_q    <= (!sa_en && td_en) ? TEST_TD : TEST_SA;
          idx_q     <= '0;
          row_q     <= '0;
          acc_q     <= '0;
          timeout_q <= 1'b0;
          fault_q   <= 1'b0;
        end
        ST_ISSUE: if (pat_ready) tcnt_q <= '0;
        ST_WAIT: begin
          if (res_valid) begin
            acc_q <= acc_q | res_fault_flat;
            if (|res_fault_flat) fault_q <= 1'b1;
            if (!last_pat) idx_q <= idx_q + MAX_ADDR_WIDTH'(1);
            else if (to_td) begin
              type_q <= TEST_TD;
              idx_q  <= '0;
            end else row_q <= '0;
          end else if (tmo_hit) begin
            timeout_q <= 1'b1;
            row_q     <= '0;
          end else tcnt_q <= tcnt_q + TW'(1);
        end
        ST_STORE: row_q <= row_q + ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

  // Column `row_q` is bit row_q of every row in the flattened map
  always_comb begin
    col_vec = '0;
    for (int i = 0; i < S; i++) col_vec[i] = acc_q[i*S + int'(row_q)];
  end
  assign row_vec = acc_q[int'(row_q)*S +: S];

  fault_line_counter #(.WIDTH(S), .CNT_W(PW), .THRESHOLD(LINE_FAULT_THRESHOLD)) u_row_cnt (
    .bits    (row_vec),
    .flagged (row_flag)
  );

  fault_line_counter #(.WIDTH(S), .CNT_W(PW), .THRESHOLD(LINE_FAULT_THRESHOLD)) u_col_cnt (
    .bits    (col_vec),
    .flagged (col_flag)
  );

  assign pat_valid              = (state == ST_ISSUE);
  assign test_type              = type_q;
  assign test_counter           = idx_q;
  assign detection_en           = (state == ST_STORE);
  assign counter                = row_q;
  assign single_pe_detection    = detection_en ? row_vec : '0;
  assign row_fault_detection    = detection_en & row_flag;
  assign column_fault_detection = detection_en & col_flag;
  assign busy                   = (state != ST_IDLE);
  assign done                   = done_q;
  assign timeout_err            = timeout_q;
  assign fault_found            = fault_q;

endmodule

// File: tb/tb_envm_test_sequencer.sv
// Scoreboard bench: expected pattern issues and fault-map writes are queued
// per run and popped as the sequencer produces them.
module tb_envm_test_sequencer;

  localparam int S    = 8;
  localparam int AW   = 3;
  localparam int MW   = 5;
  localparam int SA_D = 12;
  localparam int TD_D = 18;
  localparam int TO   = 255;

  logic clk = 1'b0;
  logic rst, start, sa_en, td_en, pat_ready, res_valid;
  logic [S*S-1:0] res_fault_flat;
  logic test_type, pat_valid, detection_en, row_fault_detection, column_fault_detection;
  logic busy, done, timeout_err, fault_found;
  logic [MW-1:0] test_counter;
  logic [AW-1:0] counter;
  logic [S-1:0]  single_pe_detection;

  always #5 clk = ~clk;

  envm_test_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .sa_en(sa_en), .td_en(td_en),
    .test_type(test_type), .test_counter(test_counter), .pat_valid(pat_valid),
    .pat_ready(pat_ready), .res_valid(res_valid), .res_fault_flat(res_fault_flat),
    .detection_en(detection_en), .counter(counter),
    .single_pe_detection(single_pe_detection),
    .row_fault_detection(row_fault_detection),
    .column_fault_detection(column_fault_detection),
    .busy(busy), .done(done), .timeout_err(timeout_err), .fault_found(fault_found)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct { logic t; int idx; } pat_t;
  typedef struct { int r; logic [S-1:0] spd; logic rf; logic cf; } st_t;
  typedef struct { logic t; int idx; int r; int c; } inj_t;

  pat_t iss_q[$];
  st_t  st_q[$];
  inj_t inj[$];

  logic [S-1:0] cap_spd [S];
  logic         cap_rf  [S];
  logic         cap_cf  [S];

  function automatic logic [S*S-1:0] fault_of(input logic t, input int idx);
    logic [S*S-1:0] f;
    f = '0;
    foreach (inj[i]) if (inj[i].t == t && inj[i].idx == idx) f[inj[i].r*S + inj[i].c] = 1'b1;
    return f;
  endfunction

  task automatic run(input string nm, input logic sa, input logic td, input int stall_pat,
                     input int to_pat, input int rst_pat, input int exp_done);
    logic [S*S-1:0] acc;
    logic [S-1:0] rowv, colv;
    bit aborted, fin, seen, hs_pend;
    int cyc, stall_left, hs_cyc, to_cyc, cur_i, exp_i;
    logic cur_t, exp_t;
    pat_t p;
    st_t e;
    acc = '0; aborted = 0; fin = 0; seen = 0; hs_pend = 0;
    cyc = 0; stall_left = 0; hs_cyc = 0; to_cyc = -1; cur_i = 0; exp_i = 0;
    cur_t = 1'b0; exp_t = 1'b0;
    iss_q.delete(); st_q.delete();
    if (sa) for (int i = 0; i < SA_D; i++) begin
      p.t = 1'b0; p.idx = i; iss_q.push_back(p);
      if (i == to_pat) begin aborted = 1; break; end
      acc |= fault_of(1'b0, i);
    end
    if (td && !aborted) for (int i = 0; i < TD_D; i++) begin
      p.t = 1'b1; p.idx = i; iss_q.push_back(p);
      acc |= fault_of(1'b1, i);
    end
    if (sa || td) for (int r = 0; r < S; r++) begin
      rowv = acc[r*S +: S];
      for (int k = 0; k < S; k++) colv[k] = acc[k*S + r];
      e.r = r; e.spd = rowv;
      e.rf = ($countones(rowv) >= 2); e.cf = ($countones(colv) >= 2);
      st_q.push_back(e);
    end

    @(negedge clk);
    start = 1'b1; sa_en = sa; td_en = td;
    while (!fin && cyc < 3000) begin
      @(negedge clk);
      start = 1'b0; sa_en = 1'b0; td_en = 1'b0; cyc++;
      pat_ready = 1'b0; res_valid = 1'b0; res_fault_flat = '0;
      if (hs_pend) begin
        hs_pend = 0; hs_cyc = cyc;
        if (rst_pat >= 0 && cur_t == 1'b0 && cur_i == rst_pat) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk({nm, ".busy"}, busy, 0);
          chk({nm, ".pat_valid"}, pat_valid, 0);
          chk({nm, ".detection_en"}, detection_en, 0);
          chk({nm, ".test_counter"}, test_counter, 0);
          iss_q.delete(); st_q.delete();
          return;
        end
        if (!(cur_t == 1'b0 && cur_i == to_pat)) begin
          res_valid = 1'b1; res_fault_flat = fault_of(cur_t, cur_i);
        end
      end
      if (timeout_err && to_cyc < 0) to_cyc = cyc;
      if (detection_en) begin
        if (st_q.size() == 0) chk({nm, ".extra_store"}, detection_en, 0);
        else begin
          e = st_q.pop_front();
          chk({nm, ".row_idx"}, counter, e.r);
          chk({nm, ".row_pe"}, single_pe_detection, e.spd);
          chk({nm, ".row_flag"}, row_fault_detection, e.rf);
          chk({nm, ".col_flag"}, column_fault_detection, e.cf);
          cap_spd[e.r] = single_pe_detection;
          cap_rf[e.r]  = row_fault_detection;
          cap_cf[e.r]  = column_fault_detection;
        end
      end
      if (pat_valid) begin
        if (!seen) begin
          seen = 1;
          if (iss_q.size() == 0) begin
            chk({nm, ".extra_issue"}, pat_valid, 0);
            exp_t = test_type; exp_i = int'(test_counter);
          end else begin
            p = iss_q.pop_front();
            exp_t = p.t; exp_i = p.idx;
            chk({nm, ".pat_type"}, test_type, exp_t);
            chk({nm, ".pat_idx"}, test_counter, exp_i);
          end
          stall_left = (exp_t == 1'b0 && exp_i == stall_pat) ? 3 : 0;
        end else begin
          chk({nm, ".stall_type"}, test_type, exp_t);
          chk({nm, ".stall_idx"}, test_counter, exp_i);
        end
        if (stall_left > 0) stall_left--;
        else begin
          pat_ready = 1'b1; hs_pend = 1; seen = 0; cur_t = exp_t; cur_i = exp_i;
        end
      end
      if (done) begin
        fin = 1;
        if (exp_done > 0) chk({nm, ".done_cycle"}, cyc, exp_done);
        chk({nm, ".busy_at_done"}, busy, 0);
        chk({nm, ".fault_found"}, fault_found, |acc);
        chk({nm, ".timeout_err"}, timeout_err, (to_pat >= 0));
        chk({nm, ".issues_left"}, iss_q.size(), 0);
        chk({nm, ".stores_left"}, st_q.size(), 0);
        if (to_pat >= 0) chk({nm, ".timeout_delay"}, to_cyc - hs_cyc, TO);
      end
    end
    if (!fin) chk({nm, ".done_seen"}, 0, 1);
    @(negedge clk);
    chk({nm, ".done_pulse"}, done, 0);
  endtask

  initial begin
    inj_t x;
    rst = 1'b1; start = 1'b0; sa_en = 1'b0; td_en = 1'b0;
    pat_ready = 1'b0; res_valid = 1'b0; res_fault_flat = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.pat_valid", pat_valid, 0);
    chk("rst.detection_en", detection_en, 0);
    chk("rst.test_counter", test_counter, 0);
    chk("rst.test_type", test_type, 0);
    chk("rst.flags", {timeout_err, fault_found}, 0);
    rst = 1'b0;

    run("rst_mid", 1'b1, 1'b0, -1, -1, 5, 0);
    run("sa_only", 1'b1, 1'b0, -1, -1, -1, 34);
    run("full_bp", 1'b1, 1'b1, 4, -1, -1, 73);

    x = '{1'b0, 0, 2, 3}; inj.push_back(x);
    x = '{1'b1, 7, 2, 5}; inj.push_back(x);
    x = '{1'b1, 9, 6, 3}; inj.push_back(x);
    run("faults", 1'b1, 1'b1, -1, -1, -1, 70);
    chk("faults.row2_pe", cap_spd[2], 8'b0010_1000);
    chk("faults.row2_flag", cap_rf[2], 1);
    chk("faults.col3_flag", cap_cf[3], 1);
    chk("faults.row6_flag", cap_rf[6], 0);
    inj.delete();

    x = '{1'b0, 1, 1, 1}; inj.push_back(x);
    x = '{1'b0, 1, 1, 4}; inj.push_back(x);
    x = '{1'b0, 3, 0, 0}; inj.push_back(x);
    run("timeout", 1'b1, 1'b0, -1, 3, -1, 0);
    chk("timeout.row1_pe", cap_spd[1], 8'b0001_0010);
    chk("timeout.row0_pe", cap_spd[0], 8'b0000_0000);
    inj.delete();

    run("none", 1'b0, 1'b0, -1, -1, -1, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/envm_test_sequencer.md
Name: envm_test_sequencer

Overview:
- Built-in self-test controller for the systolic array. Steps through the stuck-at (SA) and transition-delay (TD) pattern sets held in the eNVM pattern store by driving test_type/test_counter.
- Hands each pattern to the array test engine over a valid/ready handshake, then OR-accumulates the per-PE fault results it returns.
- When testing ends, writes the faulty-PE map, plus derived faulty-row and faulty-column flags, back into the eNVM fault storage, one row per cycle.
- Sits between the top-level test FSM and the eNVM / array test datapath.

Parameters:
SYSTOLIC_SIZE, 8, array dimension S (S×S PEs)
ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), row index width
SA_TEST_PATTERN_DEPTH, 12, number of SA patterns
TD_TEST_PATTERN_DEPTH, 18, number of TD patterns
MAX_ADDR_WIDTH, $clog2(max(SA,TD depth)), test_counter width
LINE_FAULT_THRESHOLD, 2, faulty-PE count in a row/column at or above which that line is flagged
TIMEOUT_CYCLES, 255, maximum wait for res_valid per pattern

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a test run (sampled only in IDLE)
sa_en  in  1  run SA set (captured at start)
td_en  in  1  run TD set (captured at start)
test_type  out  1  0: SA, 1: TD; to eNVM
test_counter  out  MAX_ADDR_WIDTH  pattern index; to eNVM
pat_valid  out  1  pattern at test_type/test_counter is ready for the array
pat_ready  in  1  test engine accepts the pattern
res_valid  in  1  result for the accepted pattern is valid
res_fault_flat  in  S*S  per-PE fail bits, bit r*S+c = PE(r,c)
detection_en  out  1  eNVM fault-storage write enable
counter  out  ADDR_WIDTH  row index being written
single_pe_detection  out  S  accumulated fault bits of row `counter`
row_fault_detection  out  1  row `counter` flagged
column_fault_detection  out  1  column `counter` flagged
busy  out  1  run in progress
done  out  1  one-cycle pulse at end of run
timeout_err  out  1  sticky until next start; a result timed out
fault_found  out  1  sticky until next start; any PE failed

Behaviour:
- Clock/reset: single clock clk; rst is synchronous and active-high.
- Reset, taken at any state including mid-run: state = IDLE; all outputs 0; accumulators, flags and index registers cleared.
- States: IDLE, ISSUE, WAIT, STORE, FIN.
- IDLE:
  - start=1 → capture sa_en/td_en; clear accumulators, timeout_err and fault_found.
  - If sa_en → ISSUE with type=0, idx=0. Else if td_en → ISSUE with type=1, idx=0. Else → FIN, with no eNVM write.
  - start is ignored in all other states.
- ISSUE:
  - pat_valid=1; test_type/test_counter held stable until the handshake.
  - pat_valid & pat_ready → WAIT; timeout counter = 0.
- WAIT:
  - pat_valid=0.
  - res_valid=1 → acc |= res_fault_flat, then advance:
    - idx < depth(type)-1 → idx+1, ISSUE.
    - Otherwise, at the end of the SA set with TD enabled → type=1, idx=0, ISSUE.
    - Otherwise → STORE with row=0.
  - res_valid is ignored outside WAIT, including in the handshake cycle itself.
  - Timeout counter reaches TIMEOUT_CYCLES with no res_valid → timeout_err=1; abandon remaining patterns; → STORE.
- STORE (exactly S cycles), for r = 0..S-1:
  - detection_en=1, counter=r, single_pe_detection=acc row r.
  - row_fault_detection = popcount(acc row r) ≥ LINE_FAULT_THRESHOLD.
  - column_fault_detection = popcount(acc column r) ≥ LINE_FAULT_THRESHOLD.
  - Popcount width is ADDR_WIDTH+1.
  - After r=S-1 → FIN.
- FIN: done=1 for one cycle → IDLE.
- busy=1 in every state except IDLE. done and busy are never both high.
- fault_found is set on any accepted result with a nonzero bit.
- Latency, SA only, zero-wait engine: 2 cycles per pattern (ISSUE+WAIT), so a full run is 1+2*12+8+1 cycles from start to done.
- All outputs are registered or decoded from state; no combinational path from pat_ready or res_valid to outputs.

Decomposition:
- Shared package strait_test_pkg:
  - state enum.
  - TEST_SA/TEST_TD constants.
  - Pattern depths.
  - Field-width functions (clog2 of max depth).
- One sub-module, fault_line_counter: popcount of an S-bit vector compared against the threshold. Instantiated twice: row slice, and column slice gathered from the accumulator.

Test Plan:
- Reset mid-run: rst asserted in WAIT at pattern 5 → next cycle IDLE, busy=0, pat_valid=0, detection_en=0; a following start runs cleanly from idx 0.
- SA-only run: sa_en=1, td_en=0, pat_ready=1, res_valid one cycle after each handshake, all-zero faults → test_counter goes 0..11, test_type=0; 8 store writes with all data 0; done at cycle 34; fault_found=0.
- Full SA+TD run with engine backpressure: pat_ready held low 3 cycles on pattern 4 → test_counter stable during the stall; 12 SA then 18 TD patterns; test_type switches to 1 after SA idx 11.
- Fault accumulation:
  - Inputs: PE(2,3) fails on SA pattern 0, PE(2,5) fails on TD pattern 7, PE(6,3) fails on TD pattern 9.
  - Store for row 2: single_pe_detection=8'b0010_1000, row_fault_detection=1.
  - Store for row 3: column_fault_detection=1.
  - Store for row 6: row_fault_detection=0.
  - fault_found=1.
- Timeout: res_valid withheld on SA pattern 3 → after 255 cycles timeout_err=1, STORE entered with faults accumulated so far, done pulses, no further pattern issued.
- Neither set enabled: start with sa_en=td_en=0 → done pulses 2 cycles after start; detection_en stays 0; pat_valid never asserted.
